br_flow_sum_reduce: RTL and testbench
=====================================

Name: br_flow_sum_reduce

Overview:
- Ready/valid reduction stage that sits directly downstream of a registered adder stage.
- Consumes a stream of unsigned Width-bit beats grouped into frames by push_last.
- Accumulates each frame into a saturating SumWidth-bit sum.
- Emits one result per frame (sum, beat count, overflow flag) on a ready/valid pop interface with full backpressure.

Parameters:
- Width, 4: bit width of push_data; must be >= 1.
- SumWidth, 5: bit width of the accumulator and pop_sum; must be >= Width.
- MaxBeats, 4: maximum beats per frame; a frame reaching MaxBeats is force-closed; must be >= 1.
- CountWidth, $clog2(MaxBeats+1): derived localparam, width of the beat counter and pop_count.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- push_ready  output  1  stage can accept a beat.
- push_valid  input  1  beat offered.
- push_data  input  Width  unsigned beat value.
- push_last  input  1  final beat of frame.
- pop_ready  input  1  consumer accepts the result.
- pop_valid  output  1  result available.
- pop_sum  output  SumWidth  saturated frame sum.
- pop_count  output  CountWidth  beats in frame, 1..MaxBeats.
- pop_overflow  output  1  sum saturated at some point during the frame.

Behaviour:
- Reset state:
  - State ACCUM; accumulator and count at 0.
  - pop_valid=0, pop_sum=0, pop_count=0, pop_overflow=0.
  - push_ready=1 in the first cycle after reset deasserts.
- Push and pop events: push = push_valid & push_ready; pop = pop_valid & pop_ready.
- Add rule:
  - next = acc + zero-extended push_data, computed at SumWidth+1 bits.
  - If the carry bit is set, the result is all-ones and the overflow flag is set.
  - The overflow flag is sticky within the frame.
- Frame close: a push where push_last=1 or count+1==MaxBeats.
  - The closed result is registered into the pop_* registers.
  - The accumulator, count and flag are cleared.
  - State goes to HOLD.
- Latency: pop_valid is asserted the cycle after the closing beat is accepted.
- ACCUM state:
  - push_ready=1, pop_valid=0.
  - Non-closing push: update accumulator, count+1, overflow flag.
- HOLD state:
  - pop_valid=1; push_ready=pop_ready, a combinational path from pop_ready.
  - Pop without push: go to ACCUM.
  - Pop with a closing push (a 1-beat frame): load the new result and stay in HOLD.
  - Pop with a non-closing push: acc=push_data, count=1, flag=0; go to ACCUM.
  - No pop: no state change, and push_ready=0.
- Stability: pop_sum, pop_count and pop_overflow are held constant while pop_valid & !pop_ready.
- Forced close at MaxBeats: this is not an error. The next beat starts a new frame; consumers detect the split via pop_count==MaxBeats.
- Reset mid-frame or in HOLD:
  - The partial frame and the pending result are discarded.
  - Outputs return to their reset values on the next edge.
- Assertions:
  - Static: SumWidth>=Width and MaxBeats>=1.
  - Runtime: pop payload stable under backpressure.
  - Runtime: push_valid is not dropped without acceptance; this is an input assume.
  - Cover: overflow, forced close, simultaneous pop with closing push.

Decomposition:
- Package br_flow_sum_reduce_pkg:
  - State enum typedef {Accum, Hold}, 1-bit encoding.
  - No other shared constants; widths are parameter-derived.
- One sub-module br_sat_add:
  - Combinational.
  - Inputs: a[SumWidth], b[Width].
  - Outputs: sum[SumWidth], sat.
  - Reused by the accumulate and new-frame-load paths.

Test Plan:
- Frame 5, then 3 with last, pop_ready=1 → the cycle after the 3 is accepted: pop_valid=1, pop_sum=8, pop_count=2, pop_overflow=0.
- Frame 15,15,15 with last on the third beat → pop_sum=31, pop_count=3, pop_overflow=1.
- Beats 1,1,1,1 with last=0 throughout, then 2 with last → first result sum=4 count=4; second result sum=2 count=1.
- Backpressure:
  - Result pending with pop_ready=0 for 3 cycles and push_valid=1 → push_ready=0 and pop_sum stable.
  - Then pop_ready=1 with push_data=7 last → pop occurs and the next cycle shows pop_sum=7 count=1.
- Reset mid-frame: beats 9,9 without last, then rst for 1 cycle, then 2 with last → pop_sum=2, pop_count=1, overflow=0; no stale result appears.
- Random streams (1..MaxBeats beats, random pop_ready) vs a scoreboard model → all results match and no frame is lost or duplicated.

Source files
------------

// File: rtl/br_flow_sum_reduce_pkg.sv
// Shared types for the frame sum-reduce stage.
package br_flow_sum_reduce_pkg;

    // Accum: collecting beats of a frame; Hold: a closed result awaits the consumer.
    typedef enum logic [0:0] {
        Accum = 1'b0,
        Hold  = 1'b1
    } state_e;

endpackage

// File: rtl/br_sat_add.sv
// Unsigned saturating adder: SumWidth-bit accumulator plus zero-extended Width-bit beat.
module br_sat_add #(
    parameter int Width    = 4,
    parameter int SumWidth = 5
) (
    input  logic [SumWidth-1:0] a,
    input  logic [Width-1:0]    b,
    output logic [SumWidth-1:0] sum,
    output logic                sat
);

    logic [SumWidth:0] raw;

    // Add at one extra bit; a carry out clamps the result to all-ones.
    always_comb begin
        raw = {1'b0, a} + (SumWidth + 1)'(b);
        sat = raw[SumWidth];
        sum = sat ? '1 : raw[SumWidth-1:0];
    end

endmodule

// File: rtl/br_flow_sum_reduce.sv
// Ready/valid frame reducer: saturating per-frame sum, beat count and overflow flag,
// one result per frame on a fully back-pressured pop interface.
module br_flow_sum_reduce
    import br_flow_sum_reduce_pkg::*;
#(
    parameter  int Width      = 4,
    parameter  int SumWidth   = 5,
    parameter  int MaxBeats   = 4,
    localparam int CountWidth = $clog2(MaxBeats + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  push_ready,
    input  logic                  push_valid,
    input  logic [Width-1:0]      push_data,
    input  logic                  push_last,
    input  logic                  pop_ready,
    output logic                  pop_valid,
    output logic [SumWidth-1:0]   pop_sum,
    output logic [CountWidth-1:0] pop_count,
    output logic                  pop_overflow
);

    localparam logic [CountWidth-1:0] MaxCnt = CountWidth'(MaxBeats);

    if (SumWidth < Width) begin : g_bad_sumwidth
        $error("br_flow_sum_reduce: SumWidth must be >= Width");
    end
    if (MaxBeats < 1) begin : g_bad_maxbeats
        $error("br_flow_sum_reduce: MaxBeats must be >= 1");
    end

    state_e                state_q, state_d;
    logic [SumWidth-1:0]   acc_q, acc_d;
    logic [CountWidth-1:0] cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [SumWidth-1:0]   res_sum_q, res_sum_d;
    logic [CountWidth-1:0] res_cnt_q, res_cnt_d;
    logic                  res_ovf_q, res_ovf_d;

    logic                  push;
    logic                  pop;
    logic [SumWidth-1:0]   add_a;
    logic [SumWidth-1:0]   add_sum;
    logic                  add_sat;
    logic [CountWidth-1:0] cnt_base;
    logic                  ovf_base;
    logic [CountWidth-1:0] cnt_inc;
    logic                  frame_ovf;
    logic                  closing;

    assign push = push_valid & push_ready;
    assign pop  = pop_valid & pop_ready;

    // In Hold any accepted beat starts a fresh frame, so the adder sees a zero base.
    always_comb begin
        add_a     = (state_q == Hold) ? '0 : acc_q;
        cnt_base  = (state_q == Hold) ? '0 : cnt_q;
        ovf_base  = (state_q == Hold) ? 1'b0 : ovf_q;
        cnt_inc   = cnt_base + CountWidth'(1);
        frame_ovf = ovf_base | add_sat;
        closing   = push_last | (cnt_inc == MaxCnt);
    end

    br_sat_add #(
        .Width   (Width),
        .SumWidth(SumWidth)
    ) u_sat_add (
        .a  (add_a),
        .b  (push_data),
        .sum(add_sum),
        .sat(add_sat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= Accum;
        else     state_q <= state_d;
    end

    // Next state: a closing beat always lands in Hold; a pop without a new close returns to Accum.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            Accum: if (push && closing) state_d = Hold;
            Hold:  if (pop) state_d = (push && closing) ? Hold : Accum;
            default: state_d = Accum;
        endcase
    end

    // Handshake outputs: in Hold a beat may only enter when the pending result leaves.
    always_comb begin
        pop_valid  = (state_q == Hold);
        push_ready = (state_q == Accum) | pop_ready;
    end

    // Frame and result next-state: accumulate, or close into the result registers.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_sum_d = res_sum_q;
        res_cnt_d = res_cnt_q;
        res_ovf_d = res_ovf_q;
        if (push) begin
            if (closing) begin
                res_sum_d = add_sum;
                res_cnt_d = cnt_inc;
                res_ovf_d = frame_ovf;
                acc_d     = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
            end else begin
                acc_d = add_sum;
                cnt_d = cnt_inc;
                ovf_d = frame_ovf;
            end
        end
    end

    // Datapath registers; reset discards any partial frame and pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_sum_q <= '0;
            res_cnt_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_sum_q <= res_sum_d;
            res_cnt_q <= res_cnt_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign pop_sum      = res_sum_q;
    assign pop_count    = res_cnt_q;
    assign pop_overflow = res_ovf_q;

`ifndef SYNTHESIS
    a_pop_stable: assert property (@(posedge clk) disable iff (rst)
        (pop_valid && !pop_ready) |=> (pop_valid && $stable(pop_sum)
                                       && $stable(pop_count) && $stable(pop_overflow)));

    m_push_hold: assume property (@(posedge clk) disable iff (rst)
        (push_valid && !push_ready) |=> push_valid);

    c_overflow:   cover property (@(posedge clk) disable iff (rst) push && closing && frame_ovf);
    c_forced:     cover property (@(posedge clk) disable iff (rst) push && !push_last && (cnt_inc == MaxCnt));
    c_pop_close:  cover property (@(posedge clk) disable iff (rst) pop && push && closing);
`endif

endmodule

// File: tb/tb_br_flow_sum_reduce.sv
// Self-checking bench for br_flow_sum_reduce: directed frames plus a randomized stream
// compared against a frame-level reference model.
module tb_br_flow_sum_reduce;

    localparam int W  = 4;
    localparam int SW = 5;
    localparam int MB = 4;
    localparam int CW = $clog2(MB + 1);
    localparam int SMAX = (1 << SW) - 1;

    logic          clk;
    logic          rst;
    logic          push_ready;
    logic          push_valid;
    logic [W-1:0]  push_data;
    logic          push_last;
    logic          pop_ready;
    logic          pop_valid;
    logic [SW-1:0] pop_sum;
    logic [CW-1:0] pop_count;
    logic          pop_overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: running frame total/beat count, plus at most one pending result.
    int m_total;
    int m_cnt;
    bit m_have;
    int m_sum;
    int m_rcnt;
    bit m_rovf;
    int m_closed;
    int m_popped;

    br_flow_sum_reduce #(
        .Width   (W),
        .SumWidth(SW),
        .MaxBeats(MB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push_ready  (push_ready),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .push_last   (push_last),
        .pop_ready   (pop_ready),
        .pop_valid   (pop_valid),
        .pop_sum     (pop_sum),
        .pop_count   (pop_count),
        .pop_overflow(pop_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_total = 0;
        m_cnt   = 0;
        m_have  = 1'b0;
        m_sum   = 0;
        m_rcnt  = 0;
        m_rovf  = 1'b0;
    endtask

    // Apply inputs just after an edge, check against the model, advance one clock.
    task automatic drive_cycle(input bit v, input logic [W-1:0] d, input bit l, input bit pr,
                               output bit accepted);
        bit exp_pr;
        bit do_pop;
        bit do_push;
        push_valid = v;
        push_data  = d;
        push_last  = l;
        pop_ready  = pr;
        #1;
        exp_pr = !m_have || pr;
        chk("push_ready", push_ready, exp_pr);
        chk("pop_valid", pop_valid, m_have);
        if (m_have) begin
            chk("pop_sum", pop_sum, m_sum);
            chk("pop_count", pop_count, m_rcnt);
            chk("pop_overflow", pop_overflow, m_rovf);
        end
        accepted = v && push_ready;
        do_pop   = m_have && pr;
        do_push  = v && exp_pr;
        if (do_pop) begin
            m_have = 1'b0;
            m_popped++;
        end
        if (do_push) begin
            m_total += int'(d);
            m_cnt++;
            if (l || m_cnt == MB) begin
                m_sum   = (m_total > SMAX) ? SMAX : m_total;
                m_rovf  = (m_total > SMAX);
                m_rcnt  = m_cnt;
                m_have  = 1'b1;
                m_total = 0;
                m_cnt   = 0;
                m_closed++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        push_valid = 1'b0;
        push_data  = '0;
        push_last  = 1'b0;
        pop_ready  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit acc;
        bit v;
        logic [W-1:0] d;
        bit l;
        bit pr;
        int stable_sum;

        m_closed = 0;
        m_popped = 0;
        rst = 1'b0;
        model_reset();
        apply_reset();
        apply_reset();

        // Reset state.
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_sum", pop_sum, 0);
        chk("rst_pop_count", pop_count, 0);
        chk("rst_pop_overflow", pop_overflow, 0);
        chk("rst_push_ready", push_ready, 1);

        // Frame 5,3.
        drive_cycle(1, 4'd5, 0, 1, acc);
        drive_cycle(1, 4'd3, 1, 1, acc);
        chk("f53_valid", pop_valid, 1);
        chk("f53_sum", pop_sum, 8);
        chk("f53_count", pop_count, 2);
        chk("f53_ovf", pop_overflow, 0);
        drive_cycle(0, 4'd0, 0, 1, acc);

        // Saturating frame 15,15,15.
        drive_cycle(1, 4'd15, 0, 1, acc);
        drive_cycle(1, 4'd15, 0, 1, acc);
        drive_cycle(1, 4'd15, 1, 1, acc);
        chk("sat_sum", pop_sum, 31);
        chk("sat_count", pop_count, 3);
        chk("sat_ovf", pop_overflow, 1);
        drive_cycle(0, 4'd0, 0, 1, acc);

        // Forced close at MaxBeats, then a 1-beat frame popped simultaneously.
        for (int i = 0; i < MB; i++) drive_cycle(1, 4'd1, 0, 1, acc);
        chk("forced_valid", pop_valid, 1);
        chk("forced_sum", pop_sum, 4);
        chk("forced_count", pop_count, 4);
        drive_cycle(1, 4'd2, 1, 1, acc);
        chk("next_valid", pop_valid, 1);
        chk("next_sum", pop_sum, 2);
        chk("next_count", pop_count, 1);
        drive_cycle(0, 4'd0, 0, 1, acc);

        // Backpressure with a pending result and a waiting beat.
        drive_cycle(1, 4'd4, 1, 1, acc);
        stable_sum = int'(pop_sum);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 4'd7, 1, 0, acc);
            chk("bp_not_accepted", acc, 0);
            chk("bp_sum_stable", pop_sum, stable_sum);
        end
        drive_cycle(1, 4'd7, 1, 1, acc);
        chk("bp_accepted", acc, 1);
        chk("bp_new_sum", pop_sum, 7);
        chk("bp_new_count", pop_count, 1);
        drive_cycle(0, 4'd0, 0, 1, acc);

        // Reset mid-frame discards the partial frame.
        drive_cycle(1, 4'd9, 0, 1, acc);
        drive_cycle(1, 4'd9, 0, 1, acc);
        apply_reset();
        chk("mid_rst_valid", pop_valid, 0);
        chk("mid_rst_sum", pop_sum, 0);
        drive_cycle(1, 4'd2, 1, 1, acc);
        chk("mid_rst_res_sum", pop_sum, 2);
        chk("mid_rst_res_count", pop_count, 1);
        chk("mid_rst_res_ovf", pop_overflow, 0);
        drive_cycle(0, 4'd0, 0, 1, acc);
        chk("mid_rst_no_stale", pop_valid, 0);

        // Random stream; a beat once offered is held until accepted.
        v   = 1'b0;
        d   = '0;
        l   = 1'b0;
        acc = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (!v || acc) begin
                v = ($urandom_range(0, 9) < 7);
                d = W'($urandom_range(0, (1 << W) - 1));
                l = ($urandom_range(0, 9) < 3);
            end
            pr = ($urandom_range(0, 9) < 6);
            drive_cycle(v, d, l, pr, acc);
        end
        for (int i = 0; i < 4; i++) drive_cycle(0, 4'd0, 0, 1, acc);
        chk("drain_empty", pop_valid, 0);
        chk("frames_closed_eq_popped", m_popped, m_closed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
